des_key_schedule_ctrl: RTL
==========================

# des_key_schedule_ctrl

Sequencer for the DES key schedule. It loads a 56-bit key (already PC-1 permuted), holds the C/D halves in registers and applies the per-round rotations. Each round it feeds the halves through the 56→48 compression permutation (PC-2) and presents one 48-bit subkey per round over a valid/ready handshake. It sits between key loading and the round datapath, and supports encrypt order (K1..K16) and decrypt order (K16..K1).

## Interface
Parameters:
- none. Round count (16) and shift schedule are fixed by DES.

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  start a schedule; sampled only in IDLE
- i_key  in  56  PC-1 output, DES bit n at i_key[n-1]; C = i_key[27:0], D = i_key[55:28]; sampled with i_start
- i_decrypt  in  1  0 = K1..K16, 1 = K16..K1; sampled with i_start
- i_abort  in  1  synchronous abort; returns to IDLE, no o_done
- o_subkey  out  48  PC-2 of current C/D, DES bit n at o_subkey[n-1]
- o_subkey_valid  out  1  o_subkey and o_round valid
- i_subkey_ready  in  1  consumer accepts; transfer = valid & ready
- o_round  out  4  index of the presented subkey, 0..15, in presentation order
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse after the 16th transfer

## Operation
- States: IDLE, RUN.
- IDLE → RUN on i_start. RUN → IDLE on a transfer with o_round = 15, or on i_abort.
- Shift schedule S[r], r = 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotation in index terms:
  - Left by s: X'[k] = X[(k+s) mod 28].
  - Right by s: X'[k] = X[(k−s) mod 28].
  - Applies to C and D independently.
- Encrypt:
  - Load: C/D = key rotated left by S[0].
  - After each transfer at round r < 15: rotate left by S[r+1].
- Decrypt:
  - Load: C/D = key unrotated.
  - After each transfer at round r < 15: rotate right by S[15−r].
  - Total rotation is 28, so round 0 yields K16.
- o_subkey is combinational PC-2 of the C/D registers and is stable while valid is held.
- No transfer: C/D, o_round and o_subkey hold.
- i_start in RUN is ignored. i_key/i_decrypt changes in RUN have no effect.
- i_abort has priority over a simultaneous transfer. The next cycle is IDLE with valid = 0, round = 0 and C/D unchanged.
- i_abort in IDLE is ignored. i_abort and i_start together in IDLE: start wins.
- Reset (async, any state):
  - state = IDLE; C/D = 0, so o_subkey = 0.
  - o_round = 0, o_subkey_valid = 0, o_busy = 0, o_done = 0.

## Timing
- i_start at edge N → o_subkey_valid = 1, o_round = 0, subkey 0 on o_subkey after edge N (cycle N+1).
- Transfer at cycle M → next subkey valid in cycle M+1; no bubble.
- With ready held high: subkeys appear on cycles N+1..N+16, and o_done = 1 in cycle N+17 with valid = 0, busy = 0.
- o_busy is high exactly while o_subkey_valid is high.
- Earliest re-start: i_start in the o_done cycle (N+17) is accepted.
- Ready low: stall indefinitely, with no change on any output.

## Test plan
- Encrypt, ready = 1:
  - Stimulus: i_key = DES-order 0xF0CCAAF556678F (PC-1 of 0x133457799BBCDFF1; bit 1 = MSB of the hex), i_decrypt = 0, ready = 1.
  - Required: round 0 subkey = DES-order 0x1B02EFFC7072; round 15 = 0xCB3D8B0E17F5; o_done at N+17.
- Decrypt, same key:
  - Required: round 0 = 0xCB3D8B0E17F5, round 15 = 0x1B02EFFC7072.
  - Required: all 16 subkeys equal the encrypt sequence reversed.
- Backpressure:
  - Stimulus: pseudo-random ready, ~50% duty.
  - Required: exactly 16 transfers, in order; o_subkey/o_round stable while valid & !ready; one o_done pulse.
- Abort:
  - Stimulus: i_abort at round 7 with ready = 1 in the same cycle.
  - Required: next cycle IDLE, valid = 0, no o_done.
  - Then: a new i_start gives round 0 = correct K1.
- Async reset:
  - Stimulus: i_rst_n low mid-round 4, between clock edges.
  - Required: outputs go to 0 immediately, with no clock needed; after release the block idles until i_start.
- Start/idle corner cases:
  - Stimulus: i_start pulsed during RUN.
  - Required: ignored, sequence uncorrupted.
  - Stimulus: i_start in the o_done cycle.
  - Required: back-to-back schedule with round 0 in the following cycle.

Source files
------------

// File: rtl/des_key_schedule_ctrl.sv
// DES key-schedule sequencer: holds the PC-1 C/D halves, rotates them each round
// and presents the PC-2 subkey for that round over a valid/ready handshake.
module des_key_schedule_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [55:0] i_key,
    input  logic        i_decrypt,
    input  logic        i_abort,
    output logic [47:0] o_subkey,
    output logic        o_subkey_valid,
    input  logic        i_subkey_ready,
    output logic [3:0]  o_round,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    // PC-2 selection table, 1-based DES bit numbers over {D, C}
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [27:0] c;
    logic [27:0] d;
    logic [3:0]  round;
    logic        decrypt;
    logic        done;
    logic [55:0] cd;
    logic        transfer;

    function automatic logic [1:0] shift_amt(input logic [3:0] r);
        return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    // DES bit 1 sits at index 0, so a DES left rotation is a vector right rotation
    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    assign cd       = {d, c};
    assign transfer = (state == RUN) && i_subkey_ready;

    always_comb begin
        o_subkey = '0;
        for (int n = 0; n < 48; n++) begin
            o_subkey[n] = cd[PC2[n] - 1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            c       <= '0;
            d       <= '0;
            round   <= '0;
            decrypt <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= RUN;
                        round   <= '0;
                        decrypt <= i_decrypt;
                        if (i_decrypt) begin
                            c <= i_key[27:0];
                            d <= i_key[55:28];
                        end else begin
                            c <= rot_left(i_key[27:0], shift_amt(4'd0));
                            d <= rot_left(i_key[55:28], shift_amt(4'd0));
                        end
                    end
                end
                RUN: begin
                    // abort wins over a transfer in the same cycle and leaves C/D untouched
                    if (i_abort) begin
                        state <= IDLE;
                        round <= '0;
                    end else if (transfer) begin
                        if (round == 4'd15) begin
                            state <= IDLE;
                            round <= '0;
                            done  <= 1'b1;
                        end else begin
                            round <= round + 4'd1;
                            if (decrypt) begin
                                c <= rot_right(c, shift_amt(4'd15 - round));
                                d <= rot_right(d, shift_amt(4'd15 - round));
                            end else begin
                                c <= rot_left(c, shift_amt(round + 4'd1));
                                d <= rot_left(d, shift_amt(round + 4'd1));
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_subkey_valid = (state == RUN);
    assign o_busy         = (state == RUN);
    assign o_round        = round;
    assign o_done         = done;

endmodule
